// File: rtl/ps2_kbd_tx.sv
// ASCII-to-PS/2 keyboard transmitter: maps a character to its set-2 make code and
// drives the device-side PS/2 clock/data lines. Define PS2_KBD_TX_BREAK_EN to send make, F0, make.
module ps2_kbd_tx #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_ascii,
  output logic       in_ready,
  output logic       unmapped,
  output logic       busy,
  output logic       ps2_clk,
  output logic       ps2_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int CW = $clog2(2 * CLK_DIV + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] CLK_HI_END = CW'(CLK_DIV);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);
`ifdef PS2_KBD_TX_BREAK_EN
  localparam logic [1:0] LAST_BYTE = 2'd2;
`else
  localparam logic [1:0] LAST_BYTE = 2'd0;
`endif

  function automatic logic [7:0] fold_case(input logic [7:0] c);
    if (c >= 8'h61 && c <= 8'h7A) return c - 8'd32;
    else return c;
  endfunction

  // Returns {mapped, make_code}.
  function automatic logic [8:0] map_make(input logic [7:0] c);
    case (c)
      8'h51: return {1'b1, 8'h15};  8'h57: return {1'b1, 8'h1D};
      8'h45: return {1'b1, 8'h24};  8'h52: return {1'b1, 8'h2D};
      8'h54: return {1'b1, 8'h2C};  8'h59: return {1'b1, 8'h35};
      8'h55: return {1'b1, 8'h3C};  8'h49: return {1'b1, 8'h43};
      8'h4F: return {1'b1, 8'h44};  8'h50: return {1'b1, 8'h4D};
      8'h41: return {1'b1, 8'h1C};  8'h53: return {1'b1, 8'h1B};
      8'h44: return {1'b1, 8'h23};  8'h46: return {1'b1, 8'h2B};
      8'h47: return {1'b1, 8'h34};  8'h48: return {1'b1, 8'h33};
      8'h4A: return {1'b1, 8'h3B};  8'h4B: return {1'b1, 8'h42};
      8'h4C: return {1'b1, 8'h4B};  8'h5A: return {1'b1, 8'h1A};
      8'h58: return {1'b1, 8'h22};  8'h43: return {1'b1, 8'h21};
      8'h56: return {1'b1, 8'h2A};  8'h42: return {1'b1, 8'h32};
      8'h4E: return {1'b1, 8'h31};  8'h4D: return {1'b1, 8'h3A};
      8'h5B: return {1'b1, 8'h54};  8'h5D: return {1'b1, 8'h5B};
      8'h3B: return {1'b1, 8'h4C};  8'h27: return {1'b1, 8'h52};
      8'h20: return {1'b1, 8'h29};  8'h0D: return {1'b1, 8'h5A};
      default: return {1'b0, 8'h00};
    endcase
  endfunction

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  // Bit 0 of the frame is the start bit; the frame shifts right one bit per bit period.
  function automatic logic [10:0] build_frame(input logic [7:0] b);
    return {1'b1, odd_parity(b), b, 1'b0};
  endfunction

  state_t        state_r, state_n;
  logic [CW-1:0] cnt_r, cnt_n;
  logic [3:0]    bit_r, bit_n;
  logic [GW-1:0] gap_r, gap_n;
  logic [1:0]    byte_r, byte_n;
  logic [7:0]    make_r, make_n;
  logic [10:0]   frame_r, frame_n;
  logic          ready_r, ready_n;
  logic          unmapped_r, unmapped_n;
  logic          busy_r, busy_n;
  logic          clk_r, clk_n;
  logic          data_r, data_n;

  logic          accept_s;
  logic [8:0]    map_s;
  logic [CW-1:0] cnt_inc_s;
  logic [1:0]    byte_inc_s;

  assign accept_s   = in_valid && ready_r;
  assign map_s      = map_make(fold_case(in_ascii));
  assign cnt_inc_s  = cnt_r + CW'(1);
  assign byte_inc_s = byte_r + 2'd1;

  // Next-state and next-output logic; all outputs are registered from these values.
  always_comb begin
    state_n    = state_r;
    cnt_n      = cnt_r;
    bit_n      = bit_r;
    gap_n      = gap_r;
    byte_n     = byte_r;
    make_n     = make_r;
    frame_n    = frame_r;
    ready_n    = ready_r;
    unmapped_n = 1'b0;
    busy_n     = busy_r;
    clk_n      = clk_r;
    data_n     = data_r;
    case (state_r)
      IDLE: begin
        if (accept_s && map_s[8]) begin
          state_n = SHIFT;
          make_n  = map_s[7:0];
          frame_n = build_frame(map_s[7:0]);
          cnt_n   = '0;
          bit_n   = 4'd0;
          byte_n  = 2'd0;
          clk_n   = 1'b1;
          data_n  = 1'b0;
          ready_n = 1'b0;
          busy_n  = 1'b1;
        end else if (accept_s) begin
          unmapped_n = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == CNT_LAST && bit_r == 4'd10) begin
          state_n = GAP;
          gap_n   = '0;
          clk_n   = 1'b1;
          data_n  = 1'b1;
        end else if (cnt_r == CNT_LAST) begin
          bit_n   = bit_r + 4'd1;
          cnt_n   = '0;
          frame_n = {1'b1, frame_r[10:1]};
          clk_n   = 1'b1;
          data_n  = frame_r[1];
        end else begin
          cnt_n = cnt_inc_s;
          clk_n = (cnt_inc_s < CLK_HI_END);
        end
      end
      GAP: begin
        if (gap_r == GAP_LAST && byte_r == LAST_BYTE) begin
          state_n = IDLE;
          ready_n = 1'b1;
          busy_n  = 1'b0;
        end else if (gap_r == GAP_LAST) begin
          // Middle byte of a make/break sequence is the F0 release prefix.
          state_n = SHIFT;
          byte_n  = byte_inc_s;
          frame_n = build_frame((byte_inc_s == 2'd1) ? 8'hF0 : make_r);
          cnt_n   = '0;
          bit_n   = 4'd0;
          clk_n   = 1'b1;
          data_n  = 1'b0;
        end else begin
          gap_n = gap_r + GW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        ready_n = 1'b1;
        busy_n  = 1'b0;
        clk_n   = 1'b1;
        data_n  = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      bit_r      <= 4'd0;
      gap_r      <= '0;
      byte_r     <= 2'd0;
      make_r     <= 8'h00;
      frame_r    <= 11'h000;
      ready_r    <= 1'b1;
      unmapped_r <= 1'b0;
      busy_r     <= 1'b0;
      clk_r      <= 1'b1;
      data_r     <= 1'b1;
    end else begin
      state_r    <= state_n;
      cnt_r      <= cnt_n;
      bit_r      <= bit_n;
      gap_r      <= gap_n;
      byte_r     <= byte_n;
      make_r     <= make_n;
      frame_r    <= frame_n;
      ready_r    <= ready_n;
      unmapped_r <= unmapped_n;
      busy_r     <= busy_n;
      clk_r      <= clk_n;
      data_r     <= data_n;
    end
  end

  assign in_ready = ready_r;
  assign unmapped = unmapped_r;
  assign busy     = busy_r;
  assign ps2_clk  = clk_r;
  assign ps2_data = data_r;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Self-checking bench for ps2_kbd_tx: random and directed characters compared cycle by
// cycle against a timing/framing model derived from the PS/2 frame rules.
module tb_ps2_kbd_tx;

  localparam int D   = 4;
  localparam int GAP = 8;
  localparam int P   = 22 * D + GAP;
`ifdef PS2_KBD_TX_BREAK_EN
  localparam int N = 3;
`else
  localparam int N = 1;
`endif

  localparam string LETTERS = "QWERTYUIOPASDFGHJKLZXCVBNM";
  localparam bit [7:0] LCODES [26] = '{
    8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44, 8'h4D,
    8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42, 8'h4B,
    8'h1A, 8'h22, 8'h21, 8'h2A, 8'h32, 8'h31, 8'h3A};
  localparam string POOL = "qwertyuiopASDFGHJKLzxcvbnm[];' M#";

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_ascii = 8'h00;
  logic       in_ready, unmapped, busy, ps2_clk, ps2_data;

  int n_cmp  = 0;
  int n_fail = 0;

  ps2_kbd_tx #(.CLK_DIV(D), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ascii(in_ascii),
    .in_ready(in_ready), .unmapped(unmapped), .busy(busy),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observed vector: {unmapped, in_ready, busy, ps2_clk, ps2_data}.
  task automatic check(input logic [4:0] exp, input string tag);
    logic [4:0] obs;
    obs = {unmapped, in_ready, busy, ps2_clk, ps2_data};
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic int model_code(input logic [7:0] ch);
    string letters;
    logic [7:0] c;
    letters = LETTERS;
    c = ch;
    if (c >= 8'h61 && c <= 8'h7A) c = c - 8'd32;
    for (int i = 0; i < 26; i++)
      if (c == letters[i]) return int'(LCODES[i]);
    if (c == 8'h5B) return 'h54;
    if (c == 8'h5D) return 'h5B;
    if (c == 8'h3B) return 'h4C;
    if (c == 8'h27) return 'h52;
    if (c == 8'h20) return 'h29;
    if (c == 8'h0D) return 'h5A;
    return -1;
  endfunction

  function automatic logic frame_bit(input logic [7:0] v, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return v[k-1];
    if (k == 9) return ($countones(v) % 2 == 0);
    return 1'b1;
  endfunction

  // Expected vector t cycles after the acceptance edge.
  function automatic logic [4:0] exp_vec(input int code, input int t);
    int b, r, k, ph;
    logic [7:0] bv;
    logic c, d;
    if (t >= N * P) return 5'b01011;
    b = t / P;
    r = t % P;
    if (r >= 22 * D) begin
      c = 1'b1;
      d = 1'b1;
    end else begin
      k  = r / (2 * D);
      ph = r % (2 * D);
      bv = (b == 1) ? 8'hF0 : code[7:0];
      c  = (ph < D);
      d  = frame_bit(bv, k);
    end
    return {1'b0, 1'b0, 1'b1, c, d};
  endfunction

  // Offer a character while in_ready is known high; follow it through completion.
  task automatic send_char(input logic [7:0] ch, input string tag);
    int code;
    code = model_code(ch);
    in_valid = 1'b1;
    in_ascii = ch;
    tick();
    if (code < 0) begin
      check(5'b11011, {tag, "_unmapped_pulse"});
      in_valid = 1'b0;
      tick();
      check(5'b01011, {tag, "_unmapped_after"});
    end else begin
      for (int t = 0; t <= N * P; t++) begin
        check(exp_vec(code, t), $sformatf("%s_t%0d", tag, t));
        if (t < N * P) begin
          in_valid = $urandom_range(0, 1) == 1;
          in_ascii = 8'($urandom_range(0, 255));
          tick();
        end
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    string pool;
    logic [7:0] ch;
    pool = POOL;

    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    check(5'b01011, "reset");
    tick();
    check(5'b01011, "idle_after_reset");

    send_char(8'h41, "char_A");
    send_char(8'h71, "lower_q");
    send_char(8'h23, "hash");
    send_char(8'h20, "space");
    send_char(8'h0D, "cr_b2b");

    // Reset in the middle of bit 5 of the first frame.
    in_valid = 1'b1;
    in_ascii = 8'h45;
    tick();
    in_valid = 1'b0;
    for (int t = 0; t < 5 * 2 * D + 2; t++) begin
      check(exp_vec('h24, t), $sformatf("pre_rst_t%0d", t));
      tick();
    end
    rst_n = 1'b0;
    tick();
    check(5'b01011, "reset_mid");
    rst_n = 1'b1;
    tick();
    check(5'b01011, "idle_after_mid_reset");
    send_char(8'h6D, "after_reset_m");

    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 3))
        0: ch = 8'($urandom_range(0, 127));
        1: ch = 8'h0D;
        default: ch = pool[$urandom_range(0, pool.len() - 1)];
      endcase
      send_char(ch, $sformatf("rand%0d_%02h", i, ch));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_tx.md
# ps2_kbd_tx

ASCII-to-PS/2 keyboard transmitter: accepts one ASCII character per handshake, maps it to a PS/2 scan code set 2 make code, and drives the serial PS/2 clock/data lines as a keyboard device would. It can send the make code alone or a full make/break sequence. It is the device-side counterpart of the scancode-to-ASCII lookup on the receive path, and it serves as a keystroke source for simulation and loopback testing of the keyboard receive chain.

## Interface
- `CLK_DIV`, 4: system clocks per PS/2 half-period; must be ≥ 2.
- `GAP_CYCLES`, 8: idle system clocks after each stop bit; must be ≥ 1.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  `in_ascii` holds a character to send.
- `in_ascii`  in  8  ASCII character.
- `in_ready`  out  1  block is idle and can accept a character.
- `unmapped`  out  1  one-cycle pulse: an accepted character has no mapping and was dropped.
- `busy`  out  1  a byte sequence is in progress.
- `ps2_clk`  out  1  PS/2 clock line; idles high.
- `ps2_data`  out  1  PS/2 data line; idles high.

## Operation
- Reset values: `in_ready`=1, `unmapped`=0, `busy`=0, `ps2_clk`=1, `ps2_data`=1. State is IDLE; all counters are 0.
- **Accept.** A character is accepted when `in_valid && in_ready` at a rising edge.
  - Lowercase `a`–`z` fold to uppercase first.
- **Map (make codes).**
  - Letters: Q 15, W 1D, E 24, R 2D, T 2C, Y 35, U 3C, I 43, O 44, P 4D, A 1C, S 1B, D 23, F 2B, G 34, H 33, J 3B, K 42, L 4B, Z 1A, X 22, C 21, V 2A, B 32, N 31, M 3A.
  - Symbols and controls: `[` 54, `]` 5B, `;` 4C, `'` (0x27) 52, space 29, CR (0x0D) 5A.
- **Unmapped characters.** Any other character:
  - `unmapped`=1 for exactly the cycle after acceptance.
  - The block stays in IDLE and the lines stay idle.
  - `in_ready` stays 1.
- **Mapped characters.**
  - Byte sequence is make, F0, make (see Configuration).
  - The make code is latched at acceptance.
  - `in_ready`=0 and `busy`=1 from the acceptance edge until the sequence completes.
- **Frame.** Each byte is 11 bits, in order:
  - start bit 0;
  - 8 data bits, LSB first;
  - odd parity bit (data bits plus parity contain an odd number of ones);
  - stop bit 1.
- **States.**
  - IDLE → SHIFT on a mapped accept.
  - SHIFT → GAP after bit 10 completes.
  - GAP → SHIFT when bytes remain after `GAP_CYCLES`.
  - GAP → IDLE when no bytes remain after `GAP_CYCLES`.
- Byte index is 0..2, incremented on each SHIFT entry after the first.
- **Reset mid-sequence.** Returns the block to IDLE and the reset values at the reset edge. No partial frame is resumed.
- `in_valid` is ignored while `in_ready`=0.

## Timing
- Let T0 be the edge at which a byte's frame starts; for the first byte this is the acceptance edge. Let D = `CLK_DIV`.
- Bit k (0..10) occupies cycles [T0+2kD, T0+2kD+2D).
  - `ps2_data` changes only at the first cycle of each bit period.
  - `ps2_clk` is 1 for the first D cycles of the bit and 0 for the last D.
  - The host therefore samples a stable bit on the falling edge of `ps2_clk`.
- A frame lasts 22D cycles, followed by `GAP_CYCLES` with `ps2_clk`=1 and `ps2_data`=1.
- The next byte's T0 is the previous T0 + 22D + `GAP_CYCLES`.
- With N bytes per sequence:
  - `in_ready` returns to 1 and `busy` to 0 at acceptance + N·(22D + `GAP_CYCLES`).
  - A new character may be accepted on that same edge.
- Minimum latency from acceptance to the first start bit appearing on `ps2_data`: 0 cycles; it is registered at the acceptance edge.

## Configuration
- `PS2_KBD_TX_BREAK_EN`:
  - Defined: N=3; sequence is make, F0, make (key press then release).
  - Undefined: N=1; make code only.
  - All other behaviour is identical.

## Test plan
- **Reset.** Hold `rst_n`=0 for 3 cycles, then release → `ps2_clk`=1, `ps2_data`=1, `in_ready`=1, `busy`=0, `unmapped`=0.
- **'A' with break enabled.** D=4, GAP=8, send 0x41 (`PS2_KBD_TX_BREAK_EN` defined) → three frames:
  - 1C: bits 0,0,0,1,1,1,0,0,0,0,1 (parity 0).
  - F0: bits 0,0,0,0,0,1,1,1,1,1,1 (parity 1).
  - 1C again.
  - `in_ready` returns to 1 at acceptance + 288 cycles.
- **Lowercase and make-only.** Send 0x71 `q` with the macro undefined → one frame 15h: bits 0,1,0,1,0,1,0,0,0,0,1; `in_ready` returns to 1 at +96 cycles.
- **Unmapped character.** Send 0x23 `#` → `unmapped`=1 for exactly one cycle; `ps2_clk` and `ps2_data` stay 1; `in_ready` stays 1.
- **Back-to-back and ignored input.** Hold `in_valid`=1 with 0x20, then 0x0D queued → frames 29h then 5Ah with no overlap; a value driven while `in_ready`=0 is not transmitted.
- **Reset mid-frame.** Assert `rst_n`=0 at bit 5 of the first frame → lines return to 1/1 and `in_ready`=1 at the reset edge; the next accept starts a clean frame.
